micro_hash_core: RTL

- Downstream of the block concatenator in the verifier path.
- Takes each assembled 16-byte block (12-byte entry + 4-byte nonce) and runs an iterative 8-bit hash over it: message expansion, then one round per cycle.
- Outputs a 3-byte hash and a target-compare flag to the nonce-search controller.
- Upstream must raise block_valid in the same cycle the registered block is presented (selector delayed one cycle).

---
 rtl/micro_hash_pkg.sv | 47 ++++
 rtl/micro_hash_core_if.sv | 25 ++
 rtl/micro_hash_core_round.sv | 34 +++
 rtl/micro_hash_core.sv | 125 ++++++++++++
 4 files changed

// File: rtl/micro_hash_pkg.sv
// Shared types, constants and the reference hash for the micro hash datapath.
// golden_hash is the behavioural reference used by RTL assertions and the bench.
package micro_hash_pkg;

    typedef logic [7:0]        byte_t;
    typedef byte_t [15:0]      block_t;
    typedef byte_t [2:0]       hash_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        ROUND
    } state_t;

    localparam int    ROUNDS_DEF = 32;
    localparam int    SPLIT_DEF  = 16;
    localparam byte_t K0         = 8'h99;
    localparam byte_t K1         = 8'hA1;
    localparam byte_t H_INIT0    = 8'h01;
    localparam byte_t H_INIT1    = 8'h89;
    localparam byte_t H_INIT2    = 8'hFE;

    function automatic hash_t golden_hash(input block_t blk);
        byte_t w [ROUNDS_DEF];
        byte_t h0, h1, h2, x, k, a;
        for (int i = 0; i < 16; i++) w[i] = blk[i];
        for (int i = 16; i < ROUNDS_DEF; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
        h0 = H_INIT0;
        h1 = H_INIT1;
        h2 = H_INIT2;
        for (int i = 0; i < ROUNDS_DEF; i++) begin
            if (i <= SPLIT_DEF) begin
                k = K0;
                x = h1 ^ h2;
            end else begin
                k = K1;
                x = h0 ^ h2;
            end
            a  = {h0[6:0], h0[7]} + x + k + w[i];
            h2 = h1;
            h1 = {h0[5:0], h0[7:6]};
            h0 = a;
        end
        return {h2, h1, h0};
    endfunction

endpackage

// File: rtl/micro_hash_core_if.sv
// Block-in / hash-out bundle between the block concatenator, the hash core
// and the nonce-search controller.
interface micro_hash_core_if;
    import micro_hash_pkg::*;

    block_t block_in;
    logic   block_valid;
    byte_t  target;
    logic   block_ready;
    logic   busy;
    hash_t  hash_out;
    logic   hash_valid;
    logic   hash_ok;

    modport master (
        output block_in, block_valid, target,
        input  block_ready, busy, hash_out, hash_valid, hash_ok
    );

    modport slave (
        input  block_in, block_valid, target,
        output block_ready, busy, hash_out, hash_valid, hash_ok
    );

endinterface

// File: rtl/micro_hash_core_round.sv
// One combinational hash round: H' from H, the scheduled word and the round index.
module micro_hash_core_round
    import micro_hash_pkg::*;
#(
    parameter int    SPLIT = SPLIT_DEF,
    parameter int    IDX_W = 5,
    parameter byte_t K0    = micro_hash_pkg::K0,
    parameter byte_t K1    = micro_hash_pkg::K1
) (
    input  hash_t            i_h,
    input  byte_t            i_w,
    input  logic [IDX_W-1:0] i_idx,
    output hash_t            o_h
);

    logic  w_early;
    byte_t w_rot1;
    byte_t w_rot2;
    byte_t w_mix;
    byte_t w_k;
    byte_t w_a;

    // Early rounds mix H1^H2 with K0, late rounds mix H0^H2 with K1.
    always_comb begin
        w_early = (i_idx <= IDX_W'(SPLIT));
        w_rot1  = {i_h[0][6:0], i_h[0][7]};
        w_rot2  = {i_h[0][5:0], i_h[0][7:6]};
        w_mix   = w_early ? (i_h[1] ^ i_h[2]) : (i_h[0] ^ i_h[2]);
        w_k     = w_early ? K0 : K1;
        w_a     = w_rot1 + w_mix + w_k + i_w;
        o_h     = {i_h[1], w_rot2, w_a};
    end

endmodule

// File: rtl/micro_hash_core.sv
// Iterative 8-bit block hash: capture, message expansion, one round per cycle,
// then a registered hash and target-compare flag.
module micro_hash_core
    import micro_hash_pkg::*;
#(
    parameter int    ROUNDS = ROUNDS_DEF,
    parameter int    SPLIT  = SPLIT_DEF,
    parameter byte_t K0     = micro_hash_pkg::K0,
    parameter byte_t K1     = micro_hash_pkg::K1
) (
    input logic              clk,
    input logic              reset,
    micro_hash_core_if.slave bus
);

    localparam int               IDX_W        = $clog2(ROUNDS);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] FIRST_EXP    = IDX_W'(16);
    localparam bit               CHECK_GOLDEN = (ROUNDS == ROUNDS_DEF) && (SPLIT == SPLIT_DEF) &&
                                                (K0 == micro_hash_pkg::K0) && (K1 == micro_hash_pkg::K1);

    state_t           r_state;
    state_t           w_nextState;
    byte_t            r_w [ROUNDS];
    hash_t            r_h;
    logic [IDX_W-1:0] r_idx;
    byte_t            r_target;
    hash_t            r_hashOut;
    logic             r_hashValid;
    logic             r_hashOk;
    logic             r_resetDone;
    logic             w_ready;
    logic             w_accept;
    logic             w_lastRound;
    byte_t            w_expand;
    hash_t            w_hNext;
    block_t           w_block;

    assign w_ready     = (r_state == IDLE) && r_resetDone;
    assign w_accept    = w_ready && bus.block_valid;
    assign w_lastRound = (r_state == ROUND) && (r_idx == LAST_IDX);
    assign w_expand    = r_w[r_idx - IDX_W'(3)] | (r_w[r_idx - IDX_W'(9)] ^ r_w[r_idx - IDX_W'(14)]);

    micro_hash_core_round #(
        .SPLIT (SPLIT),
        .IDX_W (IDX_W),
        .K0    (K0),
        .K1    (K1)
    ) u_round (
        .i_h   (r_h),
        .i_w   (r_w[r_idx]),
        .i_idx (r_idx),
        .o_h   (w_hNext)
    );

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_nextState = EXPAND;
            EXPAND:  if (r_idx == LAST_IDX) w_nextState = ROUND;
            ROUND:   if (r_idx == LAST_IDX) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // r_resetDone keeps block_ready low until the first edge after reset releases.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_h         <= '0;
            r_idx       <= '0;
            r_target    <= '0;
            r_hashOut   <= '0;
            r_hashValid <= 1'b0;
            r_hashOk    <= 1'b0;
            r_resetDone <= 1'b0;
            for (int i = 0; i < ROUNDS; i++) r_w[i] <= '0;
        end else begin
            r_state     <= w_nextState;
            r_resetDone <= 1'b1;
            r_hashValid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        for (int i = 0; i < 16; i++) r_w[i] <= bus.block_in[i];
                        r_target <= bus.target;
                        r_h      <= {H_INIT2, H_INIT1, H_INIT0};
                        r_idx    <= FIRST_EXP;
                    end
                end
                EXPAND: begin
                    r_w[r_idx] <= w_expand;
                    r_idx      <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                end
                ROUND: begin
                    r_h   <= w_hNext;
                    r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                    if (w_lastRound) begin
                        r_hashOut   <= w_hNext;
                        r_hashOk    <= (w_hNext[0] < r_target) && (w_hNext[1] < r_target);
                        r_hashValid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // W[0..15] still hold the captured block during ROUND.
    always_comb begin
        w_block = '0;
        for (int i = 0; i < 16; i++) w_block[i] = r_w[i];
    end

    always_ff @(posedge clk) begin
        if (reset && CHECK_GOLDEN && w_lastRound) assert (w_hNext == golden_hash(w_block));
    end

    assign bus.block_ready = w_ready;
    assign bus.busy        = (r_state == EXPAND) || (r_state == ROUND);
    assign bus.hash_out    = r_hashOut;
    assign bus.hash_valid  = r_hashValid;
    assign bus.hash_ok     = r_hashOk;

endmodule
